segment_display_decode: RTL and testbench
=========================================

Name: segment_display_decode

Overview:
- Reader side of the two-digit seven-segment display interface.
- Samples the 14 active-low segment pins driven by the board's display logic and waits until the pattern is stable.
- Decodes the stable pattern back into the 8-bit count value and emits a one-cycle valid pulse when the value changes.
- Used in loopback self-test and in simulation benches as the checker for the display path.

Parameters:
- c_SETTLE_CYCLES, 16, consecutive identical samples required before a pattern is accepted; legal range 1..255.

Ports:
- i_Clk  in  1  system clock
- i_Rst_L  in  1  asynchronous active-low reset
- i_Segment1  in  7  tens digit, pin level (active-low); bit6=A .. bit0=G
- i_Segment2  in  7  ones digit, same format
- o_Count  out  8  last accepted value; {digit1 nibble, digit2 nibble}
- o_Valid  out  1  one-cycle pulse when o_Count is updated
- o_Error  out  1  sticky flag: a stable pattern was not a legal hex glyph

Behaviour:
- Reset: asynchronous, active-low; i_Clk is the only clock.
  - Reset values: o_Count=0, o_Valid=0, o_Error=0, state IDLE, settle counter 0.
  - Sample registers reset to 7'h7F per digit (all segments off).
- Input stage: each digit is registered once and inverted to active-high (r_Sample).
  - A previous-sample register holds the prior r_Sample.
- Settle counter: 8 bits, saturating.
  - Cleared when r_Sample != previous sample.
  - Otherwise increments.
- State IDLE:
  - If r_Sample differs from the last-decoded pattern, go to SETTLE and clear the counter.
- State SETTLE:
  - Any sample change clears the counter and stays in SETTLE (glitch restart).
  - When the counter reaches c_SETTLE_CYCLES-1 with an unchanged sample, go to DECODE.
- State DECODE (one cycle):
  - The last-decoded pattern register is loaded with r_Sample.
  - If both digits are legal and the decoded value != o_Count: o_Count updates, o_Valid=1 for this cycle, o_Error clears.
  - If both digits are legal and the value equals o_Count: no pulse, o_Error clears.
  - If either digit is illegal: o_Count holds, no pulse, o_Error sets.
  - Then return to IDLE.
- Legal glyphs (active-high ABCDEFG, hex):
  - 0=7E 1=30 2=6D 3=79 4=33 5=5B 6=5F 7=70
  - 8=7F 9=7B A=77 b=1F C=4E d=3D E=4F F=47
  - All other codes, including blank 00, are illegal.
- Latency: pin change to o_Valid high is exactly c_SETTLE_CYCLES+2 rising edges, given pins held constant throughout.
- Wrap-around: 8'hFF followed by 8'h00 decodes normally and pulses once.
- A pattern that returns to the already-accepted glyph after a glitch settles but produces no pulse.
- Reset asserted mid-SETTLE: immediate return to reset values; no pulse after release until a new pattern settles.
- o_Valid is never high for two consecutive cycles.

Optional Feature:
- Macro: SEGMENT_SYNC_EN.
- Defined: an additional two-flop synchronizer precedes the input stage on all 14 pins, for asynchronous external drive.
  - Synchronizer flops reset to pin-off (1).
  - Latency becomes c_SETTLE_CYCLES+4.
- Undefined: single input register only; latency c_SETTLE_CYCLES+2; inputs must be synchronous to i_Clk.

Decomposition:
- Shared package segment_pkg holds:
  - the 16 glyph localparams;
  - the blank pattern 7'h00;
  - the state encoding (IDLE, SETTLE, DECODE);
  - the digit width of 7.
- The display-driving logic reuses the glyph constants from this package.
- One sub-module: segment_glyph_to_hex.
  - Combinational: 7-bit active-high glyph in, 4-bit nibble plus legal flag out.
  - Instantiated once per digit.

Test Plan:
- Reset, then pins = ~7E/~7E held -> o_Valid stays 0 (value 00 equals reset o_Count), o_Error=0, o_Count=8'h00.
- Pins change to ~30/~6D (12) and are held -> o_Valid pulses exactly 18 cycles after the change; o_Count=8'h12.
- Digit2 glitches to ~79 for 5 cycles during settle, then returns to ~6D -> settle restarts; the pulse occurs 18 cycles after the glitch ends, or no pulse if 12 was already accepted.
- Pins = ~47/~47 (FF), then ~7E/~7E -> pulses with o_Count=8'hFF, then 8'h00.
- Pins = ~00/~30 (blank tens digit) held -> o_Error=1 and o_Count holds; a following legal 21 clears o_Error and pulses o_Count=8'h21.
- i_Rst_L pulsed low 10 cycles into settle -> outputs return to zero asynchronously and no pulse follows; with SEGMENT_SYNC_EN defined, the pulse of case 2 moves to 20 cycles.

Source files
------------

// File: rtl/segment_pkg.sv
// Shared constants for the two-digit seven-segment display path.
// Glyphs are active-high, bit6=A .. bit0=G. The display-driving logic uses
// the same constants, so encoder and checker always agree on the glyph set.
package segment_pkg;

  localparam int DIGIT_W = 7;

  localparam logic [DIGIT_W-1:0] GLYPH_0 = 7'h7E;
  localparam logic [DIGIT_W-1:0] GLYPH_1 = 7'h30;
  localparam logic [DIGIT_W-1:0] GLYPH_2 = 7'h6D;
  localparam logic [DIGIT_W-1:0] GLYPH_3 = 7'h79;
  localparam logic [DIGIT_W-1:0] GLYPH_4 = 7'h33;
  localparam logic [DIGIT_W-1:0] GLYPH_5 = 7'h5B;
  localparam logic [DIGIT_W-1:0] GLYPH_6 = 7'h5F;
  localparam logic [DIGIT_W-1:0] GLYPH_7 = 7'h70;
  localparam logic [DIGIT_W-1:0] GLYPH_8 = 7'h7F;
  localparam logic [DIGIT_W-1:0] GLYPH_9 = 7'h7B;
  localparam logic [DIGIT_W-1:0] GLYPH_A = 7'h77;
  localparam logic [DIGIT_W-1:0] GLYPH_B = 7'h1F;
  localparam logic [DIGIT_W-1:0] GLYPH_C = 7'h4E;
  localparam logic [DIGIT_W-1:0] GLYPH_D = 7'h3D;
  localparam logic [DIGIT_W-1:0] GLYPH_E = 7'h4F;
  localparam logic [DIGIT_W-1:0] GLYPH_F = 7'h47;

  // All segments off; never a legal digit.
  localparam logic [DIGIT_W-1:0] GLYPH_BLANK = 7'h00;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DECODE = 2'd2
  } seg_state_e;

endpackage

// File: rtl/segment_glyph_to_hex.sv
// Combinational decode of one active-high seven-segment glyph back to its
// hex nibble. Anything outside the sixteen hex glyphs is flagged illegal.
module segment_glyph_to_hex
  import segment_pkg::*;
(
  input  logic [DIGIT_W-1:0] glyph,
  output logic [3:0]         nibble,
  output logic               legal
);

  // Reverse lookup of the glyph table; default covers blank and junk codes
  always_comb begin
    nibble = 4'h0;
    legal  = 1'b1;
    case (glyph)
      GLYPH_0: nibble = 4'h0;
      GLYPH_1: nibble = 4'h1;
      GLYPH_2: nibble = 4'h2;
      GLYPH_3: nibble = 4'h3;
      GLYPH_4: nibble = 4'h4;
      GLYPH_5: nibble = 4'h5;
      GLYPH_6: nibble = 4'h6;
      GLYPH_7: nibble = 4'h7;
      GLYPH_8: nibble = 4'h8;
      GLYPH_9: nibble = 4'h9;
      GLYPH_A: nibble = 4'hA;
      GLYPH_B: nibble = 4'hB;
      GLYPH_C: nibble = 4'hC;
      GLYPH_D: nibble = 4'hD;
      GLYPH_E: nibble = 4'hE;
      GLYPH_F: nibble = 4'hF;
      default: legal  = 1'b0;
    endcase
  end

endmodule

// File: rtl/segment_display_decode.sv
// Reader side of the two-digit seven-segment display. Samples the 14
// active-low pins, waits for c_SETTLE_CYCLES identical samples, decodes the
// pattern to an 8-bit value and pulses o_Valid when that value changes.
// Optional macro SEGMENT_SYNC_EN adds a two-flop synchronizer on every pin
// for asynchronous drive (adds two cycles of latency).
module segment_display_decode
  import segment_pkg::*;
#(
  parameter int c_SETTLE_CYCLES = 16
)
(
  input  logic               i_Clk,
  input  logic               i_Rst_L,
  input  logic [DIGIT_W-1:0] i_Segment1,
  input  logic [DIGIT_W-1:0] i_Segment2,
  output logic [7:0]         o_Count,
  output logic               o_Valid,
  output logic               o_Error
);

  localparam int                PAIR_W      = 2 * DIGIT_W;
  localparam logic [7:0]        SETTLE_LAST = 8'(c_SETTLE_CYCLES - 1);
  localparam logic [PAIR_W-1:0] PAIR_BLANK  = {GLYPH_BLANK, GLYPH_BLANK};

  logic [PAIR_W-1:0] pins_raw;
  logic [PAIR_W-1:0] pins_in;

  assign pins_raw = {i_Segment1, i_Segment2};

`ifdef SEGMENT_SYNC_EN
  logic [PAIR_W-1:0] sync1_q, sync1_d;
  logic [PAIR_W-1:0] sync2_q, sync2_d;

  // Two-stage shift toward the input register
  always_comb begin
    sync1_d = pins_raw;
    sync2_d = sync1_q;
  end

  // Metastability filter; resets to pin-off so nothing looks lit
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sync1_q <= ~PAIR_BLANK;
      sync2_q <= ~PAIR_BLANK;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign pins_in = sync2_q;
`else
  assign pins_in = pins_raw;
`endif

  logic [PAIR_W-1:0] pin_q, pin_d;
  logic [PAIR_W-1:0] prev_q, prev_d;
  logic [PAIR_W-1:0] last_q, last_d;
  logic [PAIR_W-1:0] sample;
  logic [7:0]        counter_q, counter_d;
  logic [7:0]        count_q, count_d;
  logic              valid_q, valid_d;
  logic              error_q, error_d;
  seg_state_e        state_q, state_d;

  logic              sample_changed;
  logic [3:0]        nib1, nib2;
  logic              legal1, legal2;
  logic [7:0]        decoded;

  // Pin register holds pin level; the active-high view is its inverse
  assign sample         = ~pin_q;
  assign sample_changed = (sample != prev_q);
  assign decoded        = {nib1, nib2};

  segment_glyph_to_hex u_tens (
    .glyph  (sample[PAIR_W-1:DIGIT_W]),
    .nibble (nib1),
    .legal  (legal1)
  );

  segment_glyph_to_hex u_ones (
    .glyph  (sample[DIGIT_W-1:0]),
    .nibble (nib2),
    .legal  (legal2)
  );

  // Input stage: capture pins and remember the previous active-high sample
  always_comb begin
    pin_d  = pins_in;
    prev_d = sample;
  end

  // Settle FSM; the decode decision is registered on entry to DECODE so that
  // o_Count and o_Valid change together during the one DECODE cycle
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    count_d = count_q;
    valid_d = 1'b0;
    error_d = error_q;

    if (sample_changed) begin
      counter_d = 8'h00;
    end else if (counter_q != 8'hFF) begin
      counter_d = counter_q + 8'h01;
    end else begin
      counter_d = counter_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (sample != last_q) begin
          state_d   = ST_SETTLE;
          counter_d = 8'h00;
        end
      end
      ST_SETTLE: begin
        if (!sample_changed && (counter_q == SETTLE_LAST)) begin
          state_d = ST_DECODE;
          last_d  = sample;
          if (legal1 && legal2) begin
            error_d = 1'b0;
            if (decoded != count_q) begin
              count_d = decoded;
              valid_d = 1'b1;
            end
          end else begin
            error_d = 1'b1;
          end
        end
      end
      ST_DECODE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      pin_q     <= ~PAIR_BLANK;
      prev_q    <= PAIR_BLANK;
      last_q    <= PAIR_BLANK;
      counter_q <= 8'h00;
      count_q   <= 8'h00;
      valid_q   <= 1'b0;
      error_q   <= 1'b0;
      state_q   <= ST_IDLE;
    end else begin
      pin_q     <= pin_d;
      prev_q    <= prev_d;
      last_q    <= last_d;
      counter_q <= counter_d;
      count_q   <= count_d;
      valid_q   <= valid_d;
      error_q   <= error_d;
      state_q   <= state_d;
    end
  end

  assign o_Count = count_q;
  assign o_Valid = valid_q;
  assign o_Error = error_q;

endmodule

// File: tb/tb_segment_display_decode.sv
// Self-checking bench for segment_display_decode: a table of settled
// patterns with hand-computed results, plus glitch and reset sequences.
module tb_segment_display_decode;

  localparam int SETTLE = 16;
`ifdef SEGMENT_SYNC_EN
  localparam int EXP_LAT = SETTLE + 4;
`else
  localparam int EXP_LAT = SETTLE + 2;
`endif
  localparam int WINDOW = 32;

  logic       i_Clk;
  logic       i_Rst_L;
  logic [6:0] i_Segment1;
  logic [6:0] i_Segment2;
  logic [7:0] o_Count;
  logic       o_Valid;
  logic       o_Error;

  int checks = 0;
  int errors = 0;

  segment_display_decode #(.c_SETTLE_CYCLES(SETTLE)) dut (
    .i_Clk      (i_Clk),
    .i_Rst_L    (i_Rst_L),
    .i_Segment1 (i_Segment1),
    .i_Segment2 (i_Segment2),
    .o_Count    (o_Count),
    .o_Valid    (o_Valid),
    .o_Error    (o_Error)
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  typedef struct {
    logic [6:0] seg1;
    logic [6:0] seg2;
    bit         expPulse;
    logic [7:0] expCount;
    bit         expError;
  } vec_t;

  vec_t vecs[14];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive an active-high glyph pair onto the active-low pins, just after an edge
  task automatic applyStimulus(input logic [6:0] g1, input logic [6:0] g2);
    @(posedge i_Clk);
    #1;
    i_Segment1 = ~g1;
    i_Segment2 = ~g2;
  endtask

  // Watch n cycles, counting pulses and the cycle of the first one
  task automatic runWindow(input int n, output int pulses, output int firstAt);
    logic prevValid;
    prevValid = 1'b0;
    pulses    = 0;
    firstAt   = -1;
    for (int k = 1; k <= n; k++) begin
      @(posedge i_Clk);
      @(negedge i_Clk);
      checkOutput("valid_single_cycle", {31'b0, o_Valid & prevValid}, 32'd0);
      if (o_Valid) begin
        pulses++;
        if (firstAt < 0) firstAt = k;
      end
      prevValid = o_Valid;
    end
  endtask

  int pulses;
  int firstAt;

  initial begin
    vecs[0]  = '{7'h7E, 7'h7E, 1'b0, 8'h00, 1'b0};
    vecs[1]  = '{7'h30, 7'h6D, 1'b1, 8'h12, 1'b0};
    vecs[2]  = '{7'h47, 7'h47, 1'b1, 8'hFF, 1'b0};
    vecs[3]  = '{7'h7E, 7'h7E, 1'b1, 8'h00, 1'b0};
    vecs[4]  = '{7'h00, 7'h30, 1'b0, 8'h00, 1'b1};
    vecs[5]  = '{7'h6D, 7'h30, 1'b1, 8'h21, 1'b0};
    vecs[6]  = '{7'h5B, 7'h1F, 1'b1, 8'h5B, 1'b0};
    vecs[7]  = '{7'h4E, 7'h3D, 1'b1, 8'hCD, 1'b0};
    vecs[8]  = '{7'h5F, 7'h70, 1'b1, 8'h67, 1'b0};
    vecs[9]  = '{7'h7F, 7'h7B, 1'b1, 8'h89, 1'b0};
    vecs[10] = '{7'h77, 7'h4F, 1'b1, 8'hAE, 1'b0};
    vecs[11] = '{7'h33, 7'h7B, 1'b1, 8'h49, 1'b0};
    vecs[12] = '{7'h12, 7'h7E, 1'b0, 8'h49, 1'b1};
    vecs[13] = '{7'h33, 7'h7B, 1'b0, 8'h49, 1'b0};

    i_Rst_L    = 1'b0;
    i_Segment1 = 7'h7F;
    i_Segment2 = 7'h7F;
    #2;
    checkOutput("reset_count", {24'b0, o_Count}, 32'h00);
    checkOutput("reset_valid", {31'b0, o_Valid}, 32'd0);
    checkOutput("reset_error", {31'b0, o_Error}, 32'd0);
    repeat (3) @(posedge i_Clk);
    #1;
    i_Rst_L = 1'b1;

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].seg1, vecs[i].seg2);
      runWindow(WINDOW, pulses, firstAt);
      checkOutput($sformatf("row%0d_pulses", i), pulses, {31'b0, vecs[i].expPulse});
      if (vecs[i].expPulse)
        checkOutput($sformatf("row%0d_latency", i), firstAt, EXP_LAT);
      checkOutput($sformatf("row%0d_count", i), {24'b0, o_Count}, {24'b0, vecs[i].expCount});
      checkOutput($sformatf("row%0d_error", i), {31'b0, o_Error}, {31'b0, vecs[i].expError});
    end

    // Glitch during settle restarts the count; pulse timed from the glitch end
    applyStimulus(7'h30, 7'h6D);
    runWindow(8, pulses, firstAt);
    checkOutput("glitch_pre_pulses", pulses, 0);
    applyStimulus(7'h30, 7'h79);
    runWindow(5, pulses, firstAt);
    checkOutput("glitch_mid_pulses", pulses, 0);
    applyStimulus(7'h30, 7'h6D);
    runWindow(WINDOW, pulses, firstAt);
    checkOutput("glitch_pulses", pulses, 1);
    checkOutput("glitch_latency", firstAt, EXP_LAT);
    checkOutput("glitch_count", {24'b0, o_Count}, 32'h12);

    // Glitch that returns to the accepted value settles without a pulse
    applyStimulus(7'h30, 7'h79);
    runWindow(5, pulses, firstAt);
    checkOutput("return_mid_pulses", pulses, 0);
    applyStimulus(7'h30, 7'h6D);
    runWindow(WINDOW, pulses, firstAt);
    checkOutput("return_pulses", pulses, 0);
    checkOutput("return_count", {24'b0, o_Count}, 32'h12);
    checkOutput("return_error", {31'b0, o_Error}, 32'd0);

    // Reset mid-settle clears outputs at once and leaves nothing to pulse
    applyStimulus(7'h7E, 7'h30);
    runWindow(10, pulses, firstAt);
    checkOutput("rst_pre_pulses", pulses, 0);
    #2;
    i_Rst_L = 1'b0;
    #1;
    checkOutput("rst_async_count", {24'b0, o_Count}, 32'h00);
    checkOutput("rst_async_valid", {31'b0, o_Valid}, 32'd0);
    checkOutput("rst_async_error", {31'b0, o_Error}, 32'd0);
    i_Segment1 = ~7'h7E;
    i_Segment2 = ~7'h7E;
    repeat (3) @(posedge i_Clk);
    #1;
    i_Rst_L = 1'b1;
    runWindow(WINDOW, pulses, firstAt);
    checkOutput("rst_post_pulses", pulses, 0);
    checkOutput("rst_post_count", {24'b0, o_Count}, 32'h00);
    checkOutput("rst_post_error", {31'b0, o_Error}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
